// File: rtl/instr_queue.sv
// instr_queue: fetch-side instruction FIFO with sequential PC generation and ROB flush/redirect.
// Optional INSTR_QUEUE_BYPASS_EN: a response arriving at an empty, unstalled queue goes straight downstream.
module instr_queue #(
  parameter int          QueueAddrLength = 3,
  parameter logic [31:0] ResetPc         = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_exception_from_rob,
  input  logic [31:0] pc_from_rob,
  input  logic        is_stall_from_rob,
  input  logic        is_finish_from_fc,
  input  logic [31:0] instr_from_fc,
  output logic        is_req_to_fc,
  output logic [31:0] pc_to_fc,
  output logic        is_exception_to_fc,
  output logic        is_empty_to_reg,
  output logic [31:0] instr_to_reg,
  output logic [31:0] pc_to_reg
);
  localparam int Depth = 2 ** QueueAddrLength;
  localparam int CntW  = QueueAddrLength + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;
  state_t state, state_n;
  logic [QueueAddrLength-1:0] head, tail;
  logic [CntW-1:0] count;
  logic [31:0] fetch_pc, pc_fc_n;
  logic [31:0] instr_mem [Depth];
  logic [31:0] pc_mem [Depth];
  logic got, byp, rd, wr, can_req;
  always_comb begin
    got = state == S_WAIT && is_finish_from_fc;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = got && count == '0 && !is_stall_from_rob;
`else
    byp = 1'b0;
`endif
    rd = !is_stall_from_rob && count != '0;
    wr = got && !byp;
    // only request when a slot is still free after this fetch lands
    can_req = state == S_IDLE && count <= CntW'(Depth - 2);
    state_n = is_exception_from_rob ? S_FLUSH :
              can_req ? S_WAIT :
              (state == S_WAIT && !got) ? S_WAIT : S_IDLE;
    pc_fc_n = is_exception_from_rob ? pc_from_rob : can_req ? fetch_pc : pc_to_fc;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      is_req_to_fc <= 1'b0;
      pc_to_fc     <= ResetPc;
    end else begin
      state        <= state_n;
      is_req_to_fc <= state_n == S_WAIT;
      pc_to_fc     <= pc_fc_n;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      fetch_pc           <= ResetPc;
      is_exception_to_fc <= 1'b0;
      is_empty_to_reg    <= 1'b1;
      instr_to_reg       <= '0;
      pc_to_reg          <= '0;
    end else if (is_exception_from_rob) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      fetch_pc           <= pc_from_rob;
      is_exception_to_fc <= 1'b1;
      is_empty_to_reg    <= 1'b1;
    end else begin
      is_exception_to_fc <= 1'b0;
      if (wr) tail <= tail + 1'b1;
      if (rd) head <= head + 1'b1;
      count <= count + CntW'(wr) - CntW'(rd);
      if (got) fetch_pc <= fetch_pc + 32'd4;
      if (!is_stall_from_rob) begin
        if (rd) begin
          instr_to_reg    <= instr_mem[head];
          pc_to_reg       <= pc_mem[head];
          is_empty_to_reg <= 1'b0;
        end else if (byp) begin
          instr_to_reg    <= instr_from_fc;
          pc_to_reg       <= pc_to_fc;
          is_empty_to_reg <= 1'b0;
        end else begin
          is_empty_to_reg <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !is_exception_from_rob) begin
      instr_mem[tail] <= instr_from_fc;
      pc_mem[tail]    <= pc_to_fc;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: random and directed checks of instr_queue against a queue-based reference model.
module tb_instr_queue;
  localparam int Depth = 8;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_exception_from_rob = 1'b0;
  logic [31:0] pc_from_rob = '0;
  logic        is_stall_from_rob = 1'b0;
  logic        is_finish_from_fc = 1'b0;
  logic [31:0] instr_from_fc = '0;
  logic        is_req_to_fc, is_exception_to_fc, is_empty_to_reg;
  logic [31:0] pc_to_fc, instr_to_reg, pc_to_reg;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_q [$];
  logic        m_req, m_exc, m_empty, m_flush;
  logic [31:0] m_pc_fc, m_instr, m_pc_reg, m_fetch_pc;

  instr_queue dut (
    .clk(clk), .rst(rst),
    .is_exception_from_rob(is_exception_from_rob), .pc_from_rob(pc_from_rob),
    .is_stall_from_rob(is_stall_from_rob), .is_finish_from_fc(is_finish_from_fc),
    .instr_from_fc(instr_from_fc), .is_req_to_fc(is_req_to_fc), .pc_to_fc(pc_to_fc),
    .is_exception_to_fc(is_exception_to_fc), .is_empty_to_reg(is_empty_to_reg),
    .instr_to_reg(instr_to_reg), .pc_to_reg(pc_to_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"}, 32'(is_req_to_fc), 32'(m_req));
    chk({tag, ".pc_fc"}, pc_to_fc, m_pc_fc);
    chk({tag, ".exc_fc"}, 32'(is_exception_to_fc), 32'(m_exc));
    chk({tag, ".empty"}, 32'(is_empty_to_reg), 32'(m_empty));
    chk({tag, ".instr"}, instr_to_reg, m_instr);
    chk({tag, ".pc_reg"}, pc_to_reg, m_pc_reg);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req = 0; m_exc = 0; m_empty = 1; m_flush = 0;
    m_pc_fc = '0; m_instr = '0; m_pc_reg = '0; m_fetch_pc = '0;
  endtask

  // one clock of the fetch/queue behaviour, from pre-edge inputs and model state
  task automatic model_step();
    logic [63:0] e;
    int n;
    bit got, byp;
    n = m_q.size();
    if (is_exception_from_rob) begin
      m_q.delete();
      m_fetch_pc = pc_from_rob; m_pc_fc = pc_from_rob;
      m_req = 0; m_exc = 1; m_empty = 1; m_flush = 1;
    end else begin
      got = m_req && is_finish_from_fc;
      byp = Byp && n == 0 && !is_stall_from_rob && got;
      m_exc = 0;
      if (!is_stall_from_rob) begin
        if (n > 0) begin
          e = m_q.pop_front();
          m_instr = e[63:32]; m_pc_reg = e[31:0]; m_empty = 0;
        end else if (byp) begin
          m_instr = instr_from_fc; m_pc_reg = m_pc_fc; m_empty = 0;
        end else m_empty = 1;
      end
      if (m_flush) m_flush = 0;
      else if (!m_req) begin
        if (n + 1 <= Depth - 1) begin m_req = 1; m_pc_fc = m_fetch_pc; end
      end else if (got) begin
        if (!byp) m_q.push_back({instr_from_fc, m_pc_fc});
        m_fetch_pc += 32'd4;
        m_req = 0;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit x, input logic [31:0] xpc, input bit f, input logic [31:0] ins);
    is_stall_from_rob = s;
    is_exception_from_rob = x;
    pc_from_rob = xpc;
    is_finish_from_fc = f && m_req;
    instr_from_fc = ins;
    model_step();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic bound_ok(input string tag, input int k, input int lim);
    n_cmp++;
    assert (k < lim) else begin
      n_err++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, k, lim);
    end
  endtask

  initial begin
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    // first response 0x13 at pc 0: bypass shows it at the response edge, queue path one edge later
    cycle(0, 0, '0, 1, 32'h13);
    chk("t6_req", 32'(is_req_to_fc), 32'd1);
    cycle(0, 0, '0, 1, 32'h13);
    chk("t6_instr_edge", instr_to_reg, Byp ? 32'h13 : 32'h0);
    chk("t6_empty_edge", 32'(is_empty_to_reg), Byp ? 32'd0 : 32'd1);
    cycle(0, 0, '0, 0, '0);
    chk("t6_instr_next", instr_to_reg, 32'h13);
    chk("t6_pc_next", pc_to_reg, 32'h0);
    repeat (30) cycle(0, 0, '0, 1, $urandom);
    repeat (20) cycle(1, 0, '0, 1, $urandom);
    repeat (20) cycle(0, 0, '0, 1, $urandom);
    // flush while waiting with three entries queued
    repeat (10) cycle(0, 0, '0, 0, '0);
    k = 0;
    while (!(m_q.size() == 3 && m_req) && k < 60) begin cycle(1, 0, '0, 1, $urandom); k++; end
    bound_ok("t3_setup", k, 60);
    cycle(0, 1, 32'h1000, 0, '0);
    chk("t3_exc", 32'(is_exception_to_fc), 32'd1);
    chk("t3_empty", 32'(is_empty_to_reg), 32'd1);
    cycle(0, 0, '0, 1, $urandom);
    chk("t3_exc_clear", 32'(is_exception_to_fc), 32'd0);
    chk("t3_no_req", 32'(is_req_to_fc), 32'd0);
    cycle(0, 0, '0, 1, $urandom);
    chk("t3_req", 32'(is_req_to_fc), 32'd1);
    chk("t3_pc_fc", pc_to_fc, 32'h1000);
    repeat (12) cycle(0, 0, '0, 1, $urandom);
    // exception together with a response; redirect near the top of the address space
    k = 0;
    while (!m_req && k < 20) begin cycle(0, 0, '0, 0, '0); k++; end
    bound_ok("t4_setup", k, 20);
    cycle(0, 1, 32'hFFFF_FFF8, 1, $urandom);
    chk("t4_exc", 32'(is_exception_to_fc), 32'd1);
    repeat (12) cycle(0, 0, '0, 1, $urandom);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom);
    // asynchronous reset while waiting with five entries queued
    repeat (10) cycle(0, 0, '0, 0, '0);
    k = 0;
    while (!(m_q.size() == 5 && m_req) && k < 80) begin cycle(1, 0, '0, 1, $urandom); k++; end
    bound_ok("t5_setup", k, 80);
    is_stall_from_rob = 1'b0;
    is_finish_from_fc = 1'b0;
    model_reset();
    rst = 1'b0;
    #1;
    check_all("t5_async");
    chk("t5_empty", 32'(is_empty_to_reg), 32'd1);
    chk("t5_req", 32'(is_req_to_fc), 32'd0);
    chk("t5_pc_fc", pc_to_fc, 32'h0);
    @(posedge clk);
    #1;
    check_all("t5_hold");
    rst = 1'b1;
    repeat (20) cycle(0, 0, '0, 1, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
